hcache_miss_ctrl: RTL and testbench
===================================

// Module: hcache_miss_ctrl
// PURPOSE
//  Sequences one port of the small hash cache for a single requester: lookup, then hit return or
//  miss fetch from backing memory, write-allocate fill and response. Sits between a lookup client
//  and the cache rd/wr port on one side and the memory read channel on the other. One request in flight.
// PARAMETERS
//  MEM_ADDR_WIDTH    32    key address width; index = addr[CACHE_ADDR_WIDTH-1:0], tag = upper bits
//  CACHE_ADDR_WIDTH  13    cache index width
//  DATA_WIDTH        64    cache/memory data width
//  TAG_WIDTH         MEM_ADDR_WIDTH-CACHE_ADDR_WIDTH   derived, do not override
//  MISS_TIMEOUT      1023  cycles allowed in MEM_WAIT before error response (>=1)
//  STAT_WIDTH        32    statistics counter width
// PORTS
//  clk            in   1                     clock
//  rst_n          in   1                     async active-low reset
//  req_valid      in   1                     lookup request
//  req_ready      out  1                     high only in IDLE
//  req_addr       in   MEM_ADDR_WIDTH        lookup key address
//  rsp_valid      out  1                     response valid, held until rsp_ready
//  rsp_ready      in   1                     client accepts response
//  rsp_data       out  DATA_WIDTH            returned data (0 when rsp_err)
//  rsp_hit        out  1                     1 = served from cache
//  rsp_err        out  1                     1 = memory timeout
//  c_rd_en        out  1                     cache lookup strobe (1 cycle)
//  c_rd_addr      out  CACHE_ADDR_WIDTH      cache index
//  c_rd_din       out  TAG_WIDTH             tag to compare
//  c_rd_valid     in   1                     cache result valid (2 cycles after c_rd_en)
//  c_rd_result    in   1                     hit flag, sampled with c_rd_valid
//  c_rd_dout      in   DATA_WIDTH            hit data
//  c_wr_en        out  1                     cache fill strobe (1 cycle)
//  c_wr_addr      out  CACHE_ADDR_WIDTH      fill index
//  c_wr_data      out  DATA_WIDTH+TAG_WIDTH  {data, tag}
//  mem_rd_valid   out  1                     memory read request
//  mem_rd_ready   in   1                     memory accepts request
//  mem_rd_addr    out  MEM_ADDR_WIDTH        memory read address
//  mem_rsp_valid  in   1                     memory data beat (no backpressure)
//  mem_rsp_data   in   DATA_WIDTH            memory data
//  stat_hit/stat_miss/stat_timeout  out STAT_WIDTH  saturating counters
// BEHAVIOUR
//  - Reset: all outputs 0 except req_ready=1; FSM=IDLE; stale=0; counters 0.
//  - FSM: IDLE -(req_valid)-> LOOKUP -> WAIT -(c_rd_valid&hit)-> RESP;
//    WAIT -(c_rd_valid&!hit)-> MEM_REQ -(mem_rd_ready)-> MEM_WAIT -(mem_rsp_valid&!stale)-> FILL -> RESP;
//    MEM_WAIT -(timer==MISS_TIMEOUT)-> RESP(err); RESP -(rsp_ready)-> IDLE.
//  - req_addr registered on accept (cycle T). c_rd_en=1 at T+1 only; c_rd_valid expected T+3; hit rsp_valid T+4.
//  - c_rd_en and c_wr_en never high in the same cycle (shared address mux in cache; rd wins there).
//  - mem_rd_valid held in MEM_REQ with stable address until mem_rd_ready.
//  - FILL: c_wr_en=1 one cycle, c_wr_data={mem_rsp_data, tag}; rsp_data=mem data, rsp_hit=0.
//  - Timeout: timer clears on MEM_WAIT entry; on expiry rsp_err=1, rsp_data=0, no fill, stale<=1.
//  - stale: first mem_rsp_valid seen while stale=1 (any state) is dropped and clears stale.
//  - mem_rsp_valid outside MEM_WAIT with stale=0: ignored.
//  - rsp_* held stable while rsp_valid & !rsp_ready.
//  - Reset mid-operation: FSM to IDLE immediately; any outstanding memory beat after reset is ignored.
// CONFIGURATION
//  HCACHE_CTRL_STATS_EN defined: stat_hit/miss/timeout increment (saturate) on hit RESP entry,
//   MEM_REQ entry, timeout. Not defined: stat_* tied to 0, no counter logic.
// STRUCTURE
//  Package hcache_ctrl_pkg: FSM state encoding (IDLE..RESP), default widths.
//  Sub-module hcache_stat_cnt (saturating counter), instantiated 3x only under HCACHE_CTRL_STATS_EN.
// TESTING
//  1. Preload idx 0x005 tag 0x1 data 0xA5; req 0x0000_2005 -> c_rd_en T+1, rsp_valid T+4, hit=1, data 0xA5.
//  2. Miss 0x0000_4007 -> mem_rd_addr 0x0000_4007; mem returns 0x1234 -> c_wr_en, c_wr_data={0x1234,tag 0x2}, hit=0; repeat -> hit.
//  3. mem_rd_ready low 5 cycles -> mem_rd_valid/addr held; no timer count until accepted.
//  4. No mem response -> rsp_err=1 after 1023 cycles in MEM_WAIT, no c_wr_en; late beat then dropped, next miss fills correctly.
//  5. rsp_ready low 3 cycles -> rsp_* stable, req_ready=0; rst_n pulse in MEM_WAIT -> IDLE, outputs reset.
//  6. STATS_EN: 2 hits, 1 miss, 1 timeout -> stat_hit=2, stat_miss=2, stat_timeout=1; undefined -> all 0.

Source files
------------

// File: rtl/hcache_ctrl_pkg.sv
// Shared definitions for the hash-cache miss controller: FSM state encoding and default widths.
package hcache_ctrl_pkg;

    localparam int MEM_ADDR_WIDTH_DFLT   = 32;
    localparam int CACHE_ADDR_WIDTH_DFLT = 13;
    localparam int DATA_WIDTH_DFLT       = 64;
    localparam int MISS_TIMEOUT_DFLT     = 1023;
    localparam int STAT_WIDTH_DFLT       = 32;

    typedef logic [2:0] state_t;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_LOOKUP   = 3'd1;
    localparam logic [2:0] ST_WAIT     = 3'd2;
    localparam logic [2:0] ST_MEM_REQ  = 3'd3;
    localparam logic [2:0] ST_MEM_WAIT = 3'd4;
    localparam logic [2:0] ST_FILL     = 3'd5;
    localparam logic [2:0] ST_RESP     = 3'd6;

endpackage

// File: rtl/hcache_stat_cnt.sv
// Saturating event counter used for the controller's optional statistics.
module hcache_stat_cnt #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [WIDTH-1:0] cnt
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (inc && (cnt != {WIDTH{1'b1}})) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/hcache_miss_ctrl.sv
// Single-requester hash-cache port sequencer: lookup, hit return or miss fetch + write-allocate fill.
// Define HCACHE_CTRL_STATS_EN to build the hit/miss/timeout statistics counters.
module hcache_miss_ctrl
    import hcache_ctrl_pkg::*;
#(
    parameter int MEM_ADDR_WIDTH   = MEM_ADDR_WIDTH_DFLT,
    parameter int CACHE_ADDR_WIDTH = CACHE_ADDR_WIDTH_DFLT,
    parameter int DATA_WIDTH       = DATA_WIDTH_DFLT,
    parameter int TAG_WIDTH        = MEM_ADDR_WIDTH - CACHE_ADDR_WIDTH,
    parameter int MISS_TIMEOUT     = MISS_TIMEOUT_DFLT,
    parameter int STAT_WIDTH       = STAT_WIDTH_DFLT
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            req_valid,
    output logic                            req_ready,
    input  logic [MEM_ADDR_WIDTH-1:0]       req_addr,
    output logic                            rsp_valid,
    input  logic                            rsp_ready,
    output logic [DATA_WIDTH-1:0]           rsp_data,
    output logic                            rsp_hit,
    output logic                            rsp_err,
    output logic                            c_rd_en,
    output logic [CACHE_ADDR_WIDTH-1:0]     c_rd_addr,
    output logic [TAG_WIDTH-1:0]            c_rd_din,
    input  logic                            c_rd_valid,
    input  logic                            c_rd_result,
    input  logic [DATA_WIDTH-1:0]           c_rd_dout,
    output logic                            c_wr_en,
    output logic [CACHE_ADDR_WIDTH-1:0]     c_wr_addr,
    output logic [DATA_WIDTH+TAG_WIDTH-1:0] c_wr_data,
    output logic                            mem_rd_valid,
    input  logic                            mem_rd_ready,
    output logic [MEM_ADDR_WIDTH-1:0]       mem_rd_addr,
    input  logic                            mem_rsp_valid,
    input  logic [DATA_WIDTH-1:0]           mem_rsp_data,
    output logic [STAT_WIDTH-1:0]           stat_hit,
    output logic [STAT_WIDTH-1:0]           stat_miss,
    output logic [STAT_WIDTH-1:0]           stat_timeout
);

    localparam int TMR_W = $clog2(MISS_TIMEOUT + 1);

    state_t                    state;
    state_t                    state_nxt;
    logic [MEM_ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0]     rsp_data_q;
    logic                      rsp_hit_q;
    logic                      rsp_err_q;
    logic                      stale;
    logic [TMR_W-1:0]          timer;

    logic hit_evt;
    logic miss_evt;
    logic mem_beat;
    logic timeout_evt;

    assign hit_evt     = (state == ST_WAIT) && c_rd_valid && c_rd_result;
    assign miss_evt    = (state == ST_WAIT) && c_rd_valid && !c_rd_result;
    assign mem_beat    = (state == ST_MEM_WAIT) && mem_rsp_valid && !stale;
    assign timeout_evt = (state == ST_MEM_WAIT) && !mem_beat && (timer == TMR_W'(MISS_TIMEOUT));

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:     if (req_valid)    state_nxt = ST_LOOKUP;
            ST_LOOKUP:                     state_nxt = ST_WAIT;
            ST_WAIT:     if (hit_evt)      state_nxt = ST_RESP;
                         else if (miss_evt) state_nxt = ST_MEM_REQ;
            ST_MEM_REQ:  if (mem_rd_ready) state_nxt = ST_MEM_WAIT;
            ST_MEM_WAIT: if (mem_beat)     state_nxt = ST_FILL;
                         else if (timeout_evt) state_nxt = ST_RESP;
            ST_FILL:                       state_nxt = ST_RESP;
            ST_RESP:     if (rsp_ready)    state_nxt = ST_IDLE;
            default:                       state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            addr_q     <= '0;
            rsp_data_q <= '0;
            rsp_hit_q  <= 1'b0;
            rsp_err_q  <= 1'b0;
            stale      <= 1'b0;
            timer      <= '0;
        end else begin
            state <= state_nxt;
            if ((state == ST_IDLE) && req_valid) addr_q <= req_addr;

            // Timer is held clear while waiting for request acceptance, so it only runs in MEM_WAIT.
            if (state == ST_MEM_WAIT) timer <= timer + 1'b1;
            else                      timer <= '0;

            // The fill data doubles as response data, so the FILL write reads it back from here.
            if (hit_evt) begin
                rsp_data_q <= c_rd_dout;
                rsp_hit_q  <= 1'b1;
                rsp_err_q  <= 1'b0;
            end else if (mem_beat) begin
                rsp_data_q <= mem_rsp_data;
                rsp_hit_q  <= 1'b0;
                rsp_err_q  <= 1'b0;
            end else if (timeout_evt) begin
                rsp_data_q <= '0;
                rsp_hit_q  <= 1'b0;
                rsp_err_q  <= 1'b1;
            end

            // A timed-out request still owes one beat; swallow it wherever it lands.
            if (timeout_evt)                 stale <= 1'b1;
            else if (mem_rsp_valid && stale) stale <= 1'b0;
        end
    end

    assign req_ready    = (state == ST_IDLE);
    assign rsp_valid    = (state == ST_RESP);
    assign rsp_data     = rsp_data_q;
    assign rsp_hit      = rsp_hit_q;
    assign rsp_err      = rsp_err_q;
    assign c_rd_en      = (state == ST_LOOKUP);
    assign c_rd_addr    = addr_q[CACHE_ADDR_WIDTH-1:0];
    assign c_rd_din     = addr_q[MEM_ADDR_WIDTH-1:CACHE_ADDR_WIDTH];
    assign c_wr_en      = (state == ST_FILL);
    assign c_wr_addr    = addr_q[CACHE_ADDR_WIDTH-1:0];
    assign c_wr_data    = {rsp_data_q, addr_q[MEM_ADDR_WIDTH-1:CACHE_ADDR_WIDTH]};
    assign mem_rd_valid = (state == ST_MEM_REQ);
    assign mem_rd_addr  = addr_q;

`ifdef HCACHE_CTRL_STATS_EN
    hcache_stat_cnt #(.WIDTH(STAT_WIDTH)) u_stat_hit (
        .clk(clk), .rst_n(rst_n), .inc(hit_evt), .cnt(stat_hit)
    );
    hcache_stat_cnt #(.WIDTH(STAT_WIDTH)) u_stat_miss (
        .clk(clk), .rst_n(rst_n), .inc(miss_evt), .cnt(stat_miss)
    );
    hcache_stat_cnt #(.WIDTH(STAT_WIDTH)) u_stat_timeout (
        .clk(clk), .rst_n(rst_n), .inc(timeout_evt), .cnt(stat_timeout)
    );
`else
    assign stat_hit     = '0;
    assign stat_miss    = '0;
    assign stat_timeout = '0;
`endif

endmodule

// File: tb/tb_hcache_miss_ctrl.sv
// Directed bench for hcache_miss_ctrl with a two-cycle-latency cache model.
module tb_hcache_miss_ctrl;

    localparam int MAW = 32;
    localparam int CAW = 13;
    localparam int DW  = 64;
    localparam int TW  = MAW - CAW;
    localparam int SW  = 32;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           req_valid = 1'b0;
    logic           req_ready;
    logic [MAW-1:0] req_addr = '0;
    logic           rsp_valid;
    logic           rsp_ready = 1'b0;
    logic [DW-1:0]  rsp_data;
    logic           rsp_hit;
    logic           rsp_err;
    logic           c_rd_en;
    logic [CAW-1:0] c_rd_addr;
    logic [TW-1:0]  c_rd_din;
    logic           c_rd_valid = 1'b0;
    logic           c_rd_result = 1'b0;
    logic [DW-1:0]  c_rd_dout = '0;
    logic           c_wr_en;
    logic [CAW-1:0] c_wr_addr;
    logic [DW+TW-1:0] c_wr_data;
    logic           mem_rd_valid;
    logic           mem_rd_ready = 1'b0;
    logic [MAW-1:0] mem_rd_addr;
    logic           mem_rsp_valid = 1'b0;
    logic [DW-1:0]  mem_rsp_data = '0;
    logic [SW-1:0]  stat_hit;
    logic [SW-1:0]  stat_miss;
    logic [SW-1:0]  stat_timeout;

    int n_vec = 0;
    int n_err = 0;
    int wr_cnt = 0;
    bit overlap = 1'b0;

    hcache_miss_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_hit(rsp_hit), .rsp_err(rsp_err),
        .c_rd_en(c_rd_en), .c_rd_addr(c_rd_addr), .c_rd_din(c_rd_din),
        .c_rd_valid(c_rd_valid), .c_rd_result(c_rd_result), .c_rd_dout(c_rd_dout),
        .c_wr_en(c_wr_en), .c_wr_addr(c_wr_addr), .c_wr_data(c_wr_data),
        .mem_rd_valid(mem_rd_valid), .mem_rd_ready(mem_rd_ready), .mem_rd_addr(mem_rd_addr),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
        .stat_hit(stat_hit), .stat_miss(stat_miss), .stat_timeout(stat_timeout)
    );

    always #5 clk = ~clk;

    // Cache model: lookup result two cycles after c_rd_en, fills written on c_wr_en.
    logic [DW+TW-1:0] cmem [int];
    bit               preloaded = 1'b0;
    logic             p1 = 1'b0;
    logic [CAW-1:0]   a1 = '0;
    logic [TW-1:0]    t1 = '0;
    logic [DW+TW-1:0] ent;

    always @(posedge clk) begin
        if (!preloaded) begin
            cmem[5] = {DW'(64'hA5), TW'(1)};
            preloaded = 1'b1;
        end
        p1 <= c_rd_en;
        a1 <= c_rd_addr;
        t1 <= c_rd_din;
        c_rd_valid <= p1;
        if (p1) begin
            if (cmem.exists(int'(a1))) begin
                ent = cmem[int'(a1)];
                c_rd_result <= (ent[TW-1:0] == t1);
                c_rd_dout   <= ent[DW+TW-1:TW];
            end else begin
                c_rd_result <= 1'b0;
                c_rd_dout   <= '0;
            end
        end
        if (c_wr_en) cmem[int'(c_wr_addr)] = c_wr_data;
    end

    always @(negedge clk) begin
        if (c_wr_en) wr_cnt = wr_cnt + 1;
        if (c_rd_en && c_wr_en) overlap = 1'b1;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached, vectors=%0d", n_vec);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_req(input logic [MAW-1:0] a);
        req_valid = 1'b1;
        req_addr  = a;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int bound);
        for (int i = 0; i < bound && !rsp_valid; i++) tick();
        chk("rsp_valid_seen", rsp_valid, 1);
    endtask

    task automatic wait_mem_req();
        for (int i = 0; i < 20 && !mem_rd_valid; i++) tick();
        chk("mem_rd_valid_seen", mem_rd_valid, 1);
    endtask

    task automatic accept_rsp();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("idle_after_rsp", {rsp_valid, req_ready}, 2'b01);
    endtask

    task automatic mem_accept();
        mem_rd_ready = 1'b1;
        tick();
        mem_rd_ready = 1'b0;
    endtask

    task automatic mem_beat(input logic [DW-1:0] d);
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = d;
        tick();
        mem_rsp_valid = 1'b0;
    endtask

    int n;
    int wr_before;

    initial begin
        // Reset state
        #3;
        chk("rst_req_ready", req_ready, 1);
        chk("rst_ctrl_outs", {rsp_valid, c_rd_en, c_wr_en, mem_rd_valid, rsp_hit, rsp_err}, 6'b0);
        chk("rst_data_outs", {rsp_data, mem_rd_addr, c_rd_addr}, '0);
        chk("rst_stats", {stat_hit, stat_miss, stat_timeout}, '0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // 1: preloaded hit, exact latency
        req_valid = 1'b1;
        req_addr  = 32'h0000_2005;
        tick();
        req_valid = 1'b0;
        chk("t1_c_rd_en_T1", c_rd_en, 1);
        chk("t1_rd_addr_tag", {c_rd_addr, c_rd_din}, {13'h005, 19'h1});
        tick();
        chk("t1_c_rd_en_T2", {c_rd_en, rsp_valid}, 2'b00);
        tick();
        chk("t1_c_rd_valid_T3", {c_rd_valid, rsp_valid}, 2'b10);
        tick();
        chk("t1_rsp_T4", {rsp_valid, rsp_hit, rsp_err}, 3'b110);
        chk("t1_rsp_data", rsp_data, 64'hA5);
        accept_rsp();

        // 2: miss, fill, then repeat hits
        do_req(32'h0000_4007);
        wait_mem_req();
        chk("t2_mem_addr", mem_rd_addr, 32'h0000_4007);
        mem_accept();
        chk("t2_mem_valid_drop", mem_rd_valid, 0);
        mem_beat(64'h1234);
        chk("t2_fill_en", {c_wr_en, c_rd_en}, 2'b10);
        chk("t2_fill_addr", c_wr_addr, 13'h007);
        chk("t2_fill_data", c_wr_data, {DW'(64'h1234), TW'(2)});
        tick();
        chk("t2_rsp", {rsp_valid, rsp_hit, rsp_err, c_wr_en}, 4'b1000);
        chk("t2_rsp_data", rsp_data, 64'h1234);
        accept_rsp();
        do_req(32'h0000_4007);
        wait_rsp(10);
        chk("t2_rehit", {rsp_hit, rsp_err}, 2'b10);
        chk("t2_rehit_data", rsp_data, 64'h1234);
        accept_rsp();

        // 3: memory backpressure; timer must not run before acceptance
        do_req(32'h0000_6009);
        wait_mem_req();
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t3_mem_hold", {mem_rd_valid, mem_rd_addr}, {1'b1, 32'h0000_6009});
        end
        mem_accept();
        for (int i = 0; i < 1018; i++) tick();
        chk("t3_no_early_timeout", rsp_valid, 0);
        mem_beat(64'hCAFE);
        chk("t3_fill_en", c_wr_en, 1);
        tick();
        chk("t3_rsp", {rsp_valid, rsp_hit, rsp_err}, 3'b100);
        chk("t3_rsp_data", rsp_data, 64'hCAFE);
        accept_rsp();

        // 4: timeout, late beat dropped, next miss fills
        do_req(32'h0000_800B);
        wait_mem_req();
        mem_accept();
        wr_before = wr_cnt;
        n = 0;
        while (!rsp_valid && n < 1100) begin
            tick();
            n++;
        end
        chk("t4_timeout_latency", (n >= 1023 && n <= 1024), 1);
        chk("t4_rsp_err", {rsp_valid, rsp_hit, rsp_err}, 3'b101);
        chk("t4_rsp_data_zero", rsp_data, 64'h0);
        chk("t4_no_fill", wr_cnt, wr_before);
        accept_rsp();
        mem_beat(64'hDEAD);
        chk("t4_late_beat_ignored", {c_wr_en, req_ready}, 2'b01);
        do_req(32'h0000_A00D);
        wait_mem_req();
        mem_accept();
        mem_beat(64'h5555);
        chk("t4_next_fill", {c_wr_en, c_wr_data}, {1'b1, DW'(64'h5555), TW'(5)});
        tick();
        chk("t4_next_rsp", {rsp_valid, rsp_err, rsp_data}, {2'b10, 64'h5555});
        accept_rsp();

        // 5: response backpressure, then reset in MEM_WAIT
        do_req(32'h0000_2005);
        wait_rsp(10);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t5_rsp_hold", {rsp_valid, req_ready, rsp_hit, rsp_err, rsp_data}, {4'b1010, 64'hA5});
        end
        accept_rsp();
        do_req(32'h0000_C00F);
        wait_mem_req();
        mem_accept();
        tick();
        rst_n = 1'b0;
        #2;
        chk("t5_rst_ctrl", {req_ready, rsp_valid, mem_rd_valid, c_rd_en, c_wr_en}, 5'b10000);
        chk("t5_rst_data", {rsp_data, mem_rd_addr, rsp_hit, rsp_err}, '0);
        chk("t5_rst_stats", {stat_hit, stat_miss, stat_timeout}, '0);
        tick();
        rst_n = 1'b1;
        mem_beat(64'hBEEF);
        chk("t5_post_rst_beat", {c_wr_en, rsp_valid, req_ready}, 3'b001);
        tick();
        chk("t5_post_rst_idle", {c_wr_en, mem_rd_valid, req_ready}, 3'b001);

        // 6: 2 hits, 1 filled miss, 1 timeout
        do_req(32'h0000_2005);
        wait_rsp(10);
        accept_rsp();
        do_req(32'h0000_4007);
        wait_rsp(10);
        chk("t6_hit2", rsp_hit, 1);
        accept_rsp();
        do_req(32'h0000_E011);
        wait_mem_req();
        mem_accept();
        mem_beat(64'h7777);
        chk("t6_fill", {c_wr_en, c_wr_data}, {1'b1, DW'(64'h7777), TW'(7)});
        tick();
        accept_rsp();
        do_req(32'h0001_0013);
        wait_mem_req();
        mem_accept();
        wait_rsp(1100);
        chk("t6_timeout_err", rsp_err, 1);
        accept_rsp();
`ifdef HCACHE_CTRL_STATS_EN
        chk("t6_stats", {stat_hit, stat_miss, stat_timeout}, {32'd2, 32'd2, 32'd1});
`else
        chk("t6_stats", {stat_hit, stat_miss, stat_timeout}, '0);
`endif
        chk("rd_wr_mutex", overlap, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
